// File: rtl/usb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_pkg : shared TX status codes and IN-buffer state encoding            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package usb_pkg;

    localparam logic [1:0] TX_NAK   = 2'd0;
    localparam logic [1:0] TX_DATA  = 2'd1;
    localparam logic [1:0] TX_STALL = 2'd2;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READY = 2'd1,
        SEND  = 2'd2,
        STALL = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_ctrl_in_ep_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_ctrl_in_ep_buf_if : endpoint-side and engine-side signals of the     |
// | EP0 IN buffer. Rev 1.0                                                   |
// +--------------------------------------------------------------------------+
interface usb_ctrl_in_ep_buf_if;
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    logic       setup_token;
    logic       in_token;
    logic       tx_pkt_end;
    logic       tx_acked;
    logic [1:0] tx_status;
    logic       tx_pid_data1;
    logic       tx_data_avail;
    logic       tx_data_get;
    logic [7:0] tx_data;

    // The buffer itself
    modport slave (
        input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        input  setup_token, in_token, tx_pkt_end, tx_acked, tx_data_get,
        output in_ep_grant, in_ep_data_free, in_ep_acked,
        output tx_status, tx_pid_data1, tx_data_avail, tx_data
    );

    // Control endpoint plus protocol engine
    modport master (
        output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        output setup_token, in_token, tx_pkt_end, tx_acked, tx_data_get,
        input  in_ep_grant, in_ep_data_free, in_ep_acked,
        input  tx_status, tx_pid_data1, tx_data_avail, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/usb_byte_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_byte_ram : register array, one write port, one combinational read    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usb_byte_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [7:0]        i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output      logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/usb_ctrl_in_ep_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_ctrl_in_ep_buf : single-packet EP0 IN buffer with replay, DATA0/1    |
// | toggle and STALL hold. Rev 1.0                                           |
// +--------------------------------------------------------------------------+
module usb_ctrl_in_ep_buf
    import usb_pkg::*;
#(
    parameter int MAX_IN_PACKET_SIZE = 32
) (
    input wire logic             clk,
    input wire logic             reset_n,
    usb_ctrl_in_ep_buf_if.slave  bus
);

    localparam int IDX_W = $clog2(MAX_IN_PACKET_SIZE);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] c_max_len = PTR_W'(MAX_IN_PACKET_SIZE);

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [PTR_W-1:0]   r_pkt_len, w_pkt_len_nxt;
    logic               r_pid_data1, w_pid_data1_nxt;
    logic               r_grant;
    logic               r_acked, w_acked_nxt;

    logic               w_data_free;
    logic               w_put;
    logic               w_avail;
    logic [PTR_W-1:0]   w_wr_inc;

    assign w_data_free = (r_state == FILL) && (r_wr_ptr < c_max_len);
    assign w_put       = bus.in_ep_data_put && w_data_free;
    assign w_avail     = (r_state == SEND) && (r_rd_ptr < r_pkt_len);
    assign w_wr_inc    = r_wr_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_len   <= '0;
            r_pid_data1 <= 1'b0;
            r_grant     <= 1'b0;
            r_acked     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_pkt_len   <= w_pkt_len_nxt;
            r_pid_data1 <= w_pid_data1_nxt;
            r_grant     <= bus.in_ep_req && (r_state == FILL);
            r_acked     <= w_acked_nxt;
        end
    end

    // SETUP beats STALL, STALL beats every per-state event
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_pkt_len_nxt   = r_pkt_len;
        w_pid_data1_nxt = r_pid_data1;
        w_acked_nxt     = 1'b0;

        if (bus.setup_token) begin
            w_state_nxt     = FILL;
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_pkt_len_nxt   = '0;
            w_pid_data1_nxt = 1'b1;
        end else if (bus.in_ep_stall) begin
            w_state_nxt  = STALL;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_put) begin
                        w_wr_ptr_nxt = w_wr_inc;
                        if (bus.in_ep_data_done || (w_wr_inc == c_max_len)) begin
                            w_pkt_len_nxt = w_wr_inc;
                            w_state_nxt   = READY;
                        end
                    end else if (bus.in_ep_data_done) begin
                        w_pkt_len_nxt = r_wr_ptr;
                        w_state_nxt   = READY;
                    end
                end
                READY: begin
                    if (bus.in_token) begin
                        w_rd_ptr_nxt = '0;
                        w_state_nxt  = SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_data_get && w_avail) begin
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    end
                    if (bus.tx_pkt_end) begin
                        if (bus.tx_acked) begin
                            w_pid_data1_nxt = ~r_pid_data1;
                            w_acked_nxt     = 1'b1;
                            w_wr_ptr_nxt    = '0;
                            w_state_nxt     = FILL;
                        end else begin
                            w_rd_ptr_nxt = '0;
                            w_state_nxt  = READY;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    usb_byte_ram #(
        .DEPTH  (MAX_IN_PACKET_SIZE),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_put),
        .i_waddr (r_wr_ptr[IDX_W-1:0]),
        .i_wdata (bus.in_ep_data),
        .i_raddr (r_rd_ptr[IDX_W-1:0]),
        .o_rdata (bus.tx_data)
    );

    always_comb begin
        bus.tx_status = TX_NAK;
        case (r_state)
            READY, SEND: bus.tx_status = TX_DATA;
            STALL:       bus.tx_status = TX_STALL;
            default:     bus.tx_status = TX_NAK;
        endcase
    end

    assign bus.in_ep_grant     = r_grant;
    assign bus.in_ep_data_free = w_data_free;
    assign bus.in_ep_acked     = r_acked;
    assign bus.tx_pid_data1    = r_pid_data1;
    assign bus.tx_data_avail   = w_avail;

endmodule
`default_nettype wire

// File: tb/tb_usb_ctrl_in_ep_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_ctrl_in_ep_buf : directed + random stimulus vs packet-level model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_usb_ctrl_in_ep_buf;

    localparam int MAX = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    usb_ctrl_in_ep_buf_if bus ();

    usb_ctrl_in_ep_buf #(.MAX_IN_PACKET_SIZE(MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Packet-level model: the bytes of the packet, and where it is in its life
    logic [7:0] m_buf [$];
    bit         m_committed, m_in_xfer, m_stalled, m_pid;
    int         m_rd;
    bit         m_exp_grant, m_exp_acked;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_committed = 0; m_in_xfer = 0; m_stalled = 0; m_pid = 0; m_rd = 0;
        m_exp_grant = 0; m_exp_acked = 0;
    endtask

    task automatic clr_pulses();
        bus.in_ep_data_put = 0; bus.in_ep_data_done = 0; bus.in_ep_stall = 0;
        bus.setup_token = 0; bus.in_token = 0; bus.tx_pkt_end = 0;
        bus.tx_acked = 0; bus.tx_data_get = 0;
    endtask

    task automatic chk_outs(input string tag);
        bit   avail;
        logic [1:0] st;
        st    = m_stalled ? 2'd2 : (m_committed ? 2'd1 : 2'd0);
        avail = m_in_xfer && (m_rd < m_buf.size());
        chk({tag, "_status"}, bus.tx_status, st);
        chk({tag, "_free"}, bus.in_ep_data_free,
            !m_stalled && !m_committed && (m_buf.size() < MAX));
        chk({tag, "_avail"}, bus.tx_data_avail, avail);
        chk({tag, "_pid"}, bus.tx_pid_data1, m_pid);
        if (avail) chk({tag, "_data"}, bus.tx_data, m_buf[m_rd]);
    endtask

    // Check state-derived outputs, apply one clock of the driven inputs to the model
    task automatic tick();
        bit pushed;
        #2;
        chk_outs("cyc");
        m_exp_grant = bus.in_ep_req && !m_stalled && !m_committed;
        m_exp_acked = 0;
        if (bus.setup_token) begin
            m_buf.delete(); m_committed = 0; m_in_xfer = 0; m_stalled = 0;
            m_pid = 1; m_rd = 0;
        end else if (bus.in_ep_stall) begin
            m_buf.delete(); m_committed = 0; m_in_xfer = 0; m_stalled = 1; m_rd = 0;
        end else if (m_stalled) begin
        end else if (!m_committed) begin
            pushed = 0;
            if (bus.in_ep_data_put && m_buf.size() < MAX) begin
                m_buf.push_back(bus.in_ep_data);
                pushed = 1;
            end
            if (bus.in_ep_data_done || (pushed && m_buf.size() == MAX)) m_committed = 1;
        end else if (!m_in_xfer) begin
            if (bus.in_token) begin m_in_xfer = 1; m_rd = 0; end
        end else begin
            if (bus.tx_data_get && m_rd < m_buf.size()) m_rd++;
            if (bus.tx_pkt_end) begin
                if (bus.tx_acked) begin
                    m_pid = !m_pid; m_exp_acked = 1;
                    m_buf.delete(); m_committed = 0; m_in_xfer = 0;
                end else begin
                    m_in_xfer = 0; m_rd = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        clr_pulses();
        chk("grant", bus.in_ep_grant, m_exp_grant);
        chk("acked", bus.in_ep_acked, m_exp_acked);
    endtask

    task automatic put(input logic [7:0] b);
        bus.in_ep_data_put = 1; bus.in_ep_data = b; tick();
    endtask
    task automatic done();   bus.in_ep_data_done = 1; tick(); endtask
    task automatic in_tok(); bus.in_token = 1; tick(); endtask
    task automatic get();    bus.tx_data_get = 1; tick(); endtask
    task automatic pend(input bit ack);
        bus.tx_pkt_end = 1; bus.tx_acked = ack; tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_outs(tag);
        chk({tag, "_grant"}, bus.in_ep_grant, 0);
        chk({tag, "_acked"}, bus.in_ep_acked, 0);
    endtask

    initial begin
        bus.in_ep_req = 0; bus.in_ep_data = 0;
        clr_pulses();
        model_reset();
        #3;
        chk_reset_vals("rst");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;

        // Three-byte packet after SETUP, DATA1 then toggle on ACK
        bus.setup_token = 1; tick();
        put(8'h12); put(8'h01); put(8'h00); done();
        chk("t1_status", bus.tx_status, 1);
        in_tok();
        chk("t1_byte0", bus.tx_data, 8'h12);
        get(); get(); get();
        chk("t1_empty", bus.tx_data_avail, 0);
        chk("t1_pid1", bus.tx_pid_data1, 1);
        pend(1);
        chk("t1_ackpulse", bus.in_ep_acked, 1);
        chk("t1_free", bus.in_ep_data_free, 1);
        tick();
        chk("t1_ackonce", bus.in_ep_acked, 0);
        chk("t1_pid0", bus.tx_pid_data1, 0);

        // Full packet auto-commits
        for (int i = 0; i < MAX; i++) put(8'(8'h40 + i));
        chk("t2_nofree", bus.in_ep_data_free, 0);
        put(8'hEE);
        in_tok();
        for (int i = 0; i < MAX; i++) get();
        chk("t2_empty", bus.tx_data_avail, 0);
        pend(1);

        // Zero-length packet
        done();
        chk("zlp_status", bus.tx_status, 1);
        in_tok();
        chk("zlp_avail", bus.tx_data_avail, 0);
        pend(1);

        // NAK-less timeout: same bytes replay with the same PID
        put(8'hA1); put(8'hB2); put(8'hC3); done();
        in_tok(); get(); get(); get();
        pend(0);
        chk("retry_noack", bus.in_ep_acked, 0);
        chk("retry_status", bus.tx_status, 1);
        in_tok();
        chk("retry_byte0", bus.tx_data, 8'hA1);
        get(); get(); get();
        pend(1);

        // STALL holds until SETUP
        bus.in_ep_stall = 1; tick();
        put(8'h55); in_tok();
        chk("stall_status", bus.tx_status, 2);
        chk("stall_free", bus.in_ep_data_free, 0);
        bus.setup_token = 1; bus.in_ep_stall = 1; tick();
        chk("setup_status", bus.tx_status, 0);
        chk("setup_free", bus.in_ep_data_free, 1);
        chk("setup_pid", bus.tx_pid_data1, 1);

        // Asynchronous reset mid-SEND
        bus.in_ep_req = 1;
        put(8'h01); put(8'h02); put(8'h03); put(8'h04); done();
        in_tok(); get(); get();
        #3;
        reset_n = 0;
        model_reset();
        #1;
        chk_reset_vals("arst");
        @(posedge clk); #1;
        chk_reset_vals("arst_hold");
        reset_n = 1;
        bus.in_ep_req = 0;
        for (int i = 0; i < 5; i++) put(8'(8'hC0 + i));
        done(); in_tok();
        for (int i = 0; i < 5; i++) get();
        pend(1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.in_ep_req       = 1'($urandom_range(0, 1));
            bus.in_ep_data_put  = ($urandom_range(0, 99) < 50);
            bus.in_ep_data      = 8'($urandom);
            bus.in_ep_data_done = ($urandom_range(0, 99) < 5);
            bus.in_ep_stall     = ($urandom_range(0, 299) == 0);
            bus.setup_token     = ($urandom_range(0, 199) == 0);
            bus.in_token        = ($urandom_range(0, 99) < 15);
            bus.tx_pkt_end      = ($urandom_range(0, 99) < 8);
            bus.tx_acked        = ($urandom_range(0, 99) < 60);
            bus.tx_data_get     = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
